// File: rtl/set_pkg.sv
// Shared types and constants for the SET host: state encoding, lattice
// geometry and the bit positions of the job fields.
package set_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_VALID = 2'd2,
        DRAIN      = 2'd3
    } host_state_t;

    localparam int SET_ROWS    = 10;
    localparam int SET_COLS    = 10;
    localparam int SET_LATENCY = 11;

    localparam int FIELD_W = 4;
    localparam int CEN_W   = 16;
    localparam int RAD_W   = 8;
    localparam int JOB_W   = CEN_W + RAD_W;

    // central = {x_a, y_a, x_b, y_b}, radius = {r_a, r_b}
    localparam int CEN_XA_LSB = 12;
    localparam int CEN_YA_LSB = 8;
    localparam int CEN_XB_LSB = 4;
    localparam int CEN_YB_LSB = 0;
    localparam int RAD_RA_LSB = 4;
    localparam int RAD_RB_LSB = 0;

endpackage

// File: rtl/set_job_fifo.sv
// Synchronous job FIFO with a show-ahead head and a registered ready that
// already accounts for the push/pop happening in the current cycle.
module set_job_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == DEPTH_V);
    assign empty      = (wr_ptr == rd_ptr);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign count_next = count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    assign rdata      = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            ready <= (count_next != DEPTH_V);
        end
    end

    // NOTE: storage is deliberately not reset; empty/full come from the
    // pointers, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/set_host.sv
// Job dispatcher for the SET lattice-point counter: queues jobs, issues them
// one at a time, and returns tagged results or a timeout error.
module set_host
    import set_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 31,
    parameter int TAG_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [15:0]      job_central,
    input  logic [7:0]       job_radius,
    output logic             set_en,
    output logic [15:0]      set_central,
    output logic [7:0]       set_radius,
    input  logic             set_busy,
    input  logic             set_valid,
    input  logic [3:0]       set_candidate,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_candidate,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    host_state_t       state;
    host_state_t       state_next;
    logic              push;
    logic              pop;
    logic              capture;
    logic              abort;
    logic              fifo_empty;
    logic [JOB_W-1:0]  head;
    logic [TCNT_W-1:0] tcnt;
    logic [TAG_W-1:0]  tag_cnt;

    assign push   = job_valid && job_ready;
    assign set_en = (state == ISSUE);

    set_job_fifo #(
        .WIDTH (JOB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({job_central, job_radius}),
        .rdata (head),
        .empty (fifo_empty),
        .ready (job_ready)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !res_valid && !set_busy) state_next = ISSUE;
            end
            ISSUE: begin
                pop        = 1'b1;
                state_next = WAIT_VALID;
            end
            WAIT_VALID: begin
                if (set_valid) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end else if (tcnt == TCNT_LAST) begin
                    abort      = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!set_busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            set_central <= '0;
            set_radius  <= '0;
        end else begin
            state <= state_next;
            if (state == ISSUE)           tcnt <= '0;
            else if (state == WAIT_VALID) tcnt <= tcnt + 1'b1;
            // Bus is loaded on entry to ISSUE so it is valid alongside set_en.
            if (state_next == ISSUE) begin
                set_central <= head[JOB_W-1:RAD_W];
                set_radius  <= head[RAD_W-1:0];
            end
        end
    end

    // Single-entry result register; issue is blocked while it is occupied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid     <= 1'b0;
            res_candidate <= '0;
            res_tag       <= '0;
            res_err       <= 1'b0;
            tag_cnt       <= '0;
        end else if (res_valid && res_ready) begin
            res_valid     <= 1'b0;
            res_candidate <= '0;
            res_tag       <= '0;
            res_err       <= 1'b0;
        end else if (capture || abort) begin
            res_valid     <= 1'b1;
            res_candidate <= capture ? set_candidate : 4'd0;
            res_err       <= abort;
            res_tag       <= tag_cnt;
            tag_cnt       <= tag_cnt + 1'b1;
        end
    end

endmodule
